// File: rtl/bank_biu_wb_ctrl_pkg.sv
// bank_biu_wb_ctrl_pkg: shared FSM encoding, AXI constants and HTU opcodes for the bank BIU write side.
package bank_biu_wb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT_B  = 2'd3
    } wb_state_e;

    localparam logic [2:0] AXSIZE_32B = 3'b101;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam logic [1:0] OP_REFILL = 2'b00;
    localparam logic [1:0] OP_WB     = 2'b01;

    function automatic logic covers(input logic [1:0] have, input logic [1:0] need);
        return (have & need) == need;
    endfunction

endpackage

// File: rtl/bank_biu_wb_ctrl.sv
// bank_biu_wb_ctrl: dirty-line writeback engine; packs SC half-lines into one line and
// issues a single-beat AXI3 AW+W write, reporting completion when the matching B returns.
module bank_biu_wb_ctrl
    import bank_biu_wb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 6,
    parameter int HALF_WIDTH = DATA_WIDTH / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    htu_wb_valid_i,
    output logic                    htu_wb_ready_o,
    input  logic [ID_WIDTH-1:0]     htu_wb_set_way_i,
    input  logic [ADDR_WIDTH-1:5]   htu_wb_addr_i,
    input  logic                    sc_wb_valid_i,
    output logic                    sc_wb_ready_o,
    input  logic [HALF_WIDTH-1:0]   sc_wb_data_i,
    input  logic                    sc_wb_all_offset_i,
    input  logic [ID_WIDTH:0]       sc_wb_set_way_offset_i,
    output logic                    wb_done_o,
    output logic [1:0]              wb_resp_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [ID_WIDTH-1:0]     awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [3:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    output logic [ID_WIDTH-1:0]     wid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [STRB_WIDTH-1:0]   wstrb_o,
    output logic                    wlast_o,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    input  logic [ID_WIDTH-1:0]     bid_i,
    input  logic [1:0]              bresp_i
);

    wb_state_e state_q, state_d;

    logic [ID_WIDTH-1:0]   sw_q;
    logic [ADDR_WIDTH-1:5] addr_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [1:0]            half_q, need_q;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [1:0]            resp_q, resp_d;

    logic       req_hs, beat_hs, aw_hs, w_hs, beat_off;
    logic [1:0] beat_mask, half_new, need_new;

    assign req_hs    = htu_wb_valid_i && htu_wb_ready_o;
    assign beat_hs   = sc_wb_valid_i && sc_wb_ready_o;
    assign aw_hs     = awvalid_o && awready_i;
    assign w_hs      = wvalid_o && wready_i;
    assign beat_off  = sc_wb_set_way_offset_i[0];
    assign beat_mask = beat_off ? 2'b10 : 2'b01;
    assign half_new  = half_q | beat_mask;
    assign need_new  = sc_wb_all_offset_i ? 2'b11 : (need_q | beat_mask);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = req_hs ? ST_COLLECT : ST_IDLE;
            ST_COLLECT: state_d = beat_hs && covers(half_new, need_new) ? ST_SEND : ST_COLLECT;
            ST_SEND:    state_d = (aw_done_q || aw_hs) && (w_done_q || w_hs) ? ST_WAIT_B : ST_SEND;
            ST_WAIT_B:  state_d = wb_done_o ? ST_IDLE : ST_WAIT_B;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Beats for another line are stalled, never dropped; B for another id is left pending.
    always_comb begin
        htu_wb_ready_o = state_q == ST_IDLE;
        sc_wb_ready_o  = state_q == ST_COLLECT && sc_wb_valid_i &&
                         sc_wb_set_way_offset_i[ID_WIDTH:1] == sw_q;
        awvalid_o      = state_q == ST_SEND && !aw_done_q;
        wvalid_o       = state_q == ST_SEND && !w_done_q;
        bready_o       = state_q == ST_WAIT_B && bid_i == sw_q;
        wb_done_o      = state_q == ST_WAIT_B && bid_i == sw_q && bvalid_i;
        wb_resp_o      = wb_done_o ? bresp_i : resp_q;
    end

    assign aw_done_d = !req_hs && (aw_done_q || aw_hs);
    assign w_done_d  = !req_hs && (w_done_q || w_hs);
    assign resp_d    = wb_done_o ? bresp_i : resp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
        end
    end

    // Line buffer and tags hold no reset; the masks are cleared when a request is taken.
    always_ff @(posedge clk_i) begin
        if (req_hs) begin
            sw_q   <= htu_wb_set_way_i;
            addr_q <= htu_wb_addr_i;
            half_q <= 2'b00;
            need_q <= 2'b00;
        end
        if (beat_hs) begin
            if (beat_off) buf_q[DATA_WIDTH-1:HALF_WIDTH] <= sc_wb_data_i;
            else          buf_q[HALF_WIDTH-1:0]          <= sc_wb_data_i;
            half_q <= half_new;
            need_q <= need_new;
        end
    end

    assign awid_o    = sw_q;
    assign awaddr_o  = {addr_q, 5'b0};
    assign awlen_o   = 4'd0;
    assign awsize_o  = AXSIZE_32B;
    assign awburst_o = BURST_INCR;
    assign wid_o     = sw_q;
    assign wdata_o   = buf_q;
    assign wstrb_o   = {{(STRB_WIDTH/2){half_q[1]}}, {(STRB_WIDTH/2){half_q[0]}}};
    assign wlast_o   = 1'b1;

endmodule
